la_iosupplyseq: RTL and testbench
=================================

LA_IOSUPPLYSEQ -- requirements
Module: la_iosupplyseq

Interface
REQ-001 The block SHALL provide parameter PROP, default "DEFAULT", meaning cell type selector.
REQ-002 The block SHALL provide parameter SIDE, default "NO", meaning pad ring side: "NO", "SO", "EA" or "WE".
REQ-003 The block SHALL provide parameter RINGW, default 8, meaning io ring width.
REQ-004 The block SHALL provide parameter N, default 4, meaning number of sequenced supply domains (N >= 1).
REQ-005 The block SHALL provide parameter DW, default 8, meaning cfg_delay width.
REQ-006 The block SHALL provide parameter TIMEOUT, default 64, meaning the maximum number of WAIT cycles for pgood (>= 1).
REQ-007 The block SHALL provide port clk, input, 1 bit: the single clock.
REQ-008 The block SHALL provide port nreset, input, 1 bit: asynchronous active-low reset.
REQ-009 The block SHALL provide port en, input, 1 bit: power-up request (1) or power-down request (0).
REQ-010 The block SHALL provide port cfg_delay, input, DW bits: per-step ramp delay minus 1, in cycles.
REQ-011 The block SHALL provide port pgood, input, N bits: per-domain power-good from the supply pads.
REQ-012 The block SHALL provide port pwr_en, output, N bits: per-domain supply enable to the pads.
REQ-013 The block SHALL provide port ready, output, 1 bit: all domains up and good.
REQ-014 The block SHALL provide port fault, output, 1 bit: sticky sequencing fault.
REQ-015 The block SHALL provide port state, output, 3 bits: current FSM state code.
REQ-016 The block SHALL provide ports vdd, vss, vddio, vssio (inout, 1 bit each) and ioring (inout, RINGW bits), passed through with no logic attached.

Function
REQ-017 The FSM SHALL use state codes IDLE=0, UP=1, WAIT=2, ON=3, DOWN=4, FAULT=5; codes 6-7 SHALL return to IDLE on the next edge.
REQ-018 The internal counter cnt SHALL be max(DW, clog2(TIMEOUT+1)) bits wide and SHALL never wrap.
REQ-019 The internal index idx SHALL be clog2(N) bits wide (minimum 1 bit).
REQ-020 All outputs SHALL be registered, with no combinational path from input to output.
REQ-021 In IDLE, pwr_en SHALL be 0; en=1 SHALL move the FSM to UP with idx=0, cnt=0 and pwr_en[0]=1 on the same edge.
REQ-022 In UP, cnt SHALL increment each cycle; when cnt==cfg_delay the FSM SHALL move to WAIT with cnt=0, so UP lasts cfg_delay+1 cycles.
REQ-023 In WAIT with pgood[idx]=1 and idx==N-1, the FSM SHALL move to ON.
REQ-024 In WAIT with pgood[idx]=1 and idx<N-1, the FSM SHALL increment idx, set pwr_en[idx+1], clear cnt and move to UP.
REQ-025 In WAIT with pgood[idx]=0, cnt SHALL increment; at cnt==TIMEOUT-1 the FSM SHALL move to FAULT.
REQ-026 A pgood rising in the same cycle as the timeout SHALL win over the timeout.
REQ-027 During power-up, pwr_en SHALL have bits 0..idx set and all other bits clear; enabled bits SHALL never drop except in DOWN or FAULT.
REQ-028 In ON, ready SHALL be 1; ready SHALL be 0 in every other state.
REQ-029 In ON, any pgood bit at 0 SHALL move the FSM to FAULT; otherwise en=0 SHALL move it to DOWN with cnt=0 and idx=N-1.
REQ-030 In UP or WAIT, en=0 SHALL abort to DOWN with cnt=0 and idx held, and a timeout SHALL NOT be raised.
REQ-031 In DOWN, cnt SHALL increment; at cnt==cfg_delay the FSM SHALL clear pwr_en[idx] and cnt.
REQ-032 In DOWN, after that clear, the FSM SHALL move to IDLE if idx==0, else decrement idx.
REQ-033 Domains SHALL switch off in reverse order, each after cfg_delay+1 cycles.
REQ-034 pgood SHALL be ignored in DOWN, and en=1 during DOWN SHALL be ignored until IDLE is reached.
REQ-035 Entering FAULT SHALL clear pwr_en to 0 on the same edge and set fault=1.
REQ-036 The FSM SHALL leave FAULT only when en=0, moving to IDLE and clearing fault on that edge.
REQ-037 In ON, a pgood drop SHALL take priority over a simultaneous en=0.
REQ-038 cfg_delay SHALL be sampled every cycle; a change in cfg_delay SHALL affect the step in progress.

Reset
REQ-039 nreset=0 SHALL immediately force state=IDLE, pwr_en=0, ready=0, fault=0, cnt=0 and idx=0, from any state including mid-ramp.
REQ-040 Release of nreset SHALL take effect at the first clk edge with nreset=1, and no pwr_en bit SHALL glitch high during reset.

Verification
REQ-041 A bench SHALL check normal up: N=3, cfg_delay=2, pgood=3'b111, en=1 before edge 0 -> pwr_en 001, 011 and 111 after edges 0, 4 and 8; ready=1 after edge 12.
REQ-042 A bench SHALL check timeout: same setup, TIMEOUT=8, pgood[1] stuck at 0 -> fault=1 and pwr_en=000 after edge 15; en=0 -> IDLE with fault=0 on the next edge.
REQ-043 A bench SHALL check orderly down: from ON, en=0 -> pwr_en 011, 001 and 000 at intervals of 3 cycles, then state=0.
REQ-044 A bench SHALL check a drop in ON: pgood[2] goes low in the same cycle as en=0 -> state=5 (FAULT), not 4 (DOWN).
REQ-045 A bench SHALL check abort: en=0 while UP at idx=1 -> DOWN clears bit 1 then bit 0, with fault staying 0.
REQ-046 A bench SHALL check async reset: nreset pulsed low mid-WAIT, off any clk edge -> all outputs 0 immediately, and a fresh sequence restarts after release.

Source files
------------

// File: rtl/la_iosupplyseq.sv
// Supply-domain power sequencer: ramps N pad supply domains up in order, waiting for
// each power-good, and ramps them down in reverse order. Timeouts and drops latch a fault.
module la_iosupplyseq #(
  parameter              PROP    = "DEFAULT",
  parameter              SIDE    = "NO",
  parameter int unsigned RINGW   = 8,
  parameter int unsigned N       = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             en,
  input  logic [DW-1:0]    cfg_delay,
  input  logic [N-1:0]     pgood,
  output logic [N-1:0]     pwr_en,
  output logic             ready,
  output logic             fault,
  output logic [2:0]       state,
  inout  wire              vdd,
  inout  wire              vss,
  inout  wire              vddio,
  inout  wire              vssio,
  inout  wire  [RINGW-1:0] ioring
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned CW = (DW > TW) ? DW : TW;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] TimeoutLast = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LastIdx     = IW'(N - 1);
  localparam logic [N-1:0]  One         = N'(1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StUp    = 3'd1,
    StWait  = 3'd2,
    StOn    = 3'd3,
    StDown  = 3'd4,
    StFault = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc, dly;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  pwr_en_q, pwr_en_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;

  // Saturating increment; >= compares keep a shrinking cfg_delay from stranding a step.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign dly     = CW'(cfg_delay);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    pwr_en_d = pwr_en_q;
    unique case (state_q)
      StIdle: begin
        pwr_en_d = '0;
        cnt_d    = '0;
        idx_d    = '0;
        if (en) begin
          state_d  = StUp;
          pwr_en_d = One;
        end
      end
      StUp: begin
        if (!en) begin
          state_d = StDown;
          cnt_d   = '0;
        end else if (cnt_q >= dly) begin
          state_d = StWait;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWait: begin
        if (!en) begin
          state_d = StDown;
          cnt_d   = '0;
        end else if (pgood[idx_q]) begin
          cnt_d = '0;
          if (idx_q == LastIdx) begin
            state_d = StOn;
          end else begin
            state_d  = StUp;
            idx_d    = idx_q + 1'b1;
            pwr_en_d = pwr_en_q | (One << (idx_q + 1'b1));
          end
        end else if (cnt_q >= TimeoutLast) begin
          state_d  = StFault;
          pwr_en_d = '0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StOn: begin
        cnt_d = '0;
        if (pgood != {N{1'b1}}) begin
          state_d  = StFault;
          pwr_en_d = '0;
        end else if (!en) begin
          state_d = StDown;
          idx_d   = LastIdx;
        end
      end
      StDown: begin
        if (cnt_q >= dly) begin
          pwr_en_d = pwr_en_q & ~(One << idx_q);
          cnt_d    = '0;
          if (idx_q == '0) begin
            state_d = StIdle;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StFault: begin
        pwr_en_d = '0;
        cnt_d    = '0;
        if (!en) begin
          state_d = StIdle;
          idx_d   = '0;
        end
      end
      default: begin
        state_d  = StIdle;
        pwr_en_d = '0;
        cnt_d    = '0;
        idx_d    = '0;
      end
    endcase
    ready_d = (state_d == StOn);
    fault_d = (state_d == StFault);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      pwr_en_q <= '0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pwr_en_q <= pwr_en_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
    end
  end

  assign pwr_en = pwr_en_q;
  assign ready  = ready_q;
  assign fault  = fault_q;
  assign state  = state_q;

endmodule

// File: tb/tb_la_iosupplyseq.sv
// Directed bench for la_iosupplyseq with N=3, cfg_delay=2, TIMEOUT=8.
module tb_la_iosupplyseq;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         nreset;
  logic         en;
  logic [7:0]   cfg_delay;
  logic [N-1:0] pgood;
  logic [N-1:0] pwr_en;
  logic         ready;
  logic         fault;
  logic [2:0]   state;
  wire          vdd, vss, vddio, vssio;
  wire  [7:0]   ioring;

  int n_tests = 0;
  int n_fail  = 0;

  la_iosupplyseq #(
    .RINGW  (8),
    .N      (N),
    .DW     (8),
    .TIMEOUT(8)
  ) dut (
    .clk      (clk),
    .nreset   (nreset),
    .en       (en),
    .cfg_delay(cfg_delay),
    .pgood    (pgood),
    .pwr_en   (pwr_en),
    .ready    (ready),
    .fault    (fault),
    .state    (state),
    .vdd      (vdd),
    .vss      (vss),
    .vddio    (vddio),
    .vssio    (vssio),
    .ioring   (ioring)
  );

  always #5 clk = ~clk;

  // One posedge, then settle before sampling.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset and release at a negedge with inputs idle.
  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    en     = 1'b0;
    pgood  = 3'b111;
    #2;
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tick(2);
    n_tests++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    n_tests++;
    if (pwr_en !== 3'b000) begin n_fail++; $display("FAIL reset_pwr_en got %b want 000", pwr_en); end
    n_tests++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
    n_tests++;
    if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b want 0", fault); end
  endtask

  // Leaves the DUT in ON after edge 12.
  task automatic test_up();
    do_reset();
    pgood = 3'b111;
    en    = 1'b1;
    tick(1);  // edge 0
    n_tests++;
    if (pwr_en !== 3'b001 || state !== 3'd1) begin
      n_fail++; $display("FAIL up_e0 got pwr_en=%b state=%0d want 001/1", pwr_en, state);
    end
    tick(3);  // edge 3
    n_tests++;
    if (state !== 3'd2 || pwr_en !== 3'b001) begin
      n_fail++; $display("FAIL up_e3 got state=%0d pwr_en=%b want 2/001", state, pwr_en);
    end
    tick(1);  // edge 4
    n_tests++;
    if (pwr_en !== 3'b011) begin n_fail++; $display("FAIL up_e4 got %b want 011", pwr_en); end
    tick(4);  // edge 8
    n_tests++;
    if (pwr_en !== 3'b111) begin n_fail++; $display("FAIL up_e8 got %b want 111", pwr_en); end
    tick(3);  // edge 11
    n_tests++;
    if (ready !== 1'b0 || state !== 3'd2) begin
      n_fail++; $display("FAIL up_e11 got ready=%b state=%0d want 0/2", ready, state);
    end
    tick(1);  // edge 12
    n_tests++;
    if (ready !== 1'b1 || state !== 3'd3 || pwr_en !== 3'b111) begin
      n_fail++;
      $display("FAIL up_e12 got ready=%b state=%0d pwr_en=%b want 1/3/111", ready, state, pwr_en);
    end
  endtask

  task automatic test_down();
    test_up();
    @(negedge clk);
    en = 1'b0;
    tick(1);
    n_tests++;
    if (state !== 3'd4 || pwr_en !== 3'b111 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL down_enter got state=%0d pwr_en=%b ready=%b want 4/111/0", state, pwr_en,
               ready);
    end
    tick(2);
    n_tests++;
    if (pwr_en !== 3'b111) begin n_fail++; $display("FAIL down_hold got %b want 111", pwr_en); end
    tick(1);
    n_tests++;
    if (pwr_en !== 3'b011) begin n_fail++; $display("FAIL down_d2 got %b want 011", pwr_en); end
    tick(3);
    n_tests++;
    if (pwr_en !== 3'b001) begin n_fail++; $display("FAIL down_d1 got %b want 001", pwr_en); end
    tick(3);
    n_tests++;
    if (pwr_en !== 3'b000 || state !== 3'd0) begin
      n_fail++; $display("FAIL down_d0 got pwr_en=%b state=%0d want 000/0", pwr_en, state);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    pgood = 3'b101;
    en    = 1'b1;
    tick(15);  // edges 0..14
    n_tests++;
    if (state !== 3'd2 || fault !== 1'b0 || pwr_en !== 3'b011) begin
      n_fail++;
      $display("FAIL tmo_e14 got state=%0d fault=%b pwr_en=%b want 2/0/011", state, fault, pwr_en);
    end
    tick(1);  // edge 15
    n_tests++;
    if (fault !== 1'b1 || pwr_en !== 3'b000 || state !== 3'd5) begin
      n_fail++;
      $display("FAIL tmo_e15 got fault=%b pwr_en=%b state=%0d want 1/000/5", fault, pwr_en, state);
    end
    tick(2);
    n_tests++;
    if (fault !== 1'b1 || state !== 3'd5) begin
      n_fail++; $display("FAIL tmo_sticky got fault=%b state=%0d want 1/5", fault, state);
    end
    @(negedge clk);
    en = 1'b0;
    tick(1);
    n_tests++;
    if (state !== 3'd0 || fault !== 1'b0) begin
      n_fail++; $display("FAIL tmo_clear got state=%0d fault=%b want 0/0", state, fault);
    end
  endtask

  // pgood arriving on the timeout cycle must win.
  task automatic test_timeout_race();
    do_reset();
    pgood = 3'b101;
    en    = 1'b1;
    tick(15);  // edges 0..14
    @(negedge clk);
    pgood = 3'b111;
    tick(1);   // edge 15
    n_tests++;
    if (state !== 3'd1 || fault !== 1'b0 || pwr_en !== 3'b111) begin
      n_fail++;
      $display("FAIL race got state=%0d fault=%b pwr_en=%b want 1/0/111", state, fault, pwr_en);
    end
  endtask

  task automatic test_on_drop();
    test_up();
    @(negedge clk);
    pgood = 3'b011;
    en    = 1'b0;
    tick(1);
    n_tests++;
    if (state !== 3'd5 || fault !== 1'b1 || pwr_en !== 3'b000 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL drop got state=%0d fault=%b pwr_en=%b ready=%b want 5/1/000/0", state, fault,
               pwr_en, ready);
    end
    tick(1);
    n_tests++;
    if (state !== 3'd0 || fault !== 1'b0) begin
      n_fail++; $display("FAIL drop_exit got state=%0d fault=%b want 0/0", state, fault);
    end
  endtask

  task automatic test_abort();
    do_reset();
    pgood = 3'b111;
    en    = 1'b1;
    tick(5);  // edges 0..4: UP at idx 1
    n_tests++;
    if (state !== 3'd1 || pwr_en !== 3'b011) begin
      n_fail++; $display("FAIL abort_pre got state=%0d pwr_en=%b want 1/011", state, pwr_en);
    end
    @(negedge clk);
    en = 1'b0;
    tick(1);  // edge 5
    n_tests++;
    if (state !== 3'd4 || pwr_en !== 3'b011) begin
      n_fail++; $display("FAIL abort_enter got state=%0d pwr_en=%b want 4/011", state, pwr_en);
    end
    tick(3);  // edge 8
    n_tests++;
    if (pwr_en !== 3'b001 || fault !== 1'b0) begin
      n_fail++; $display("FAIL abort_d1 got pwr_en=%b fault=%b want 001/0", pwr_en, fault);
    end
    tick(3);  // edge 11
    n_tests++;
    if (pwr_en !== 3'b000 || state !== 3'd0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_d0 got pwr_en=%b state=%0d fault=%b want 000/0/0", pwr_en, state, fault);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    pgood = 3'b001;
    en    = 1'b1;
    tick(10);  // edges 0..9: WAIT at idx 1
    n_tests++;
    if (state !== 3'd2 || pwr_en !== 3'b011) begin
      n_fail++; $display("FAIL arst_pre got state=%0d pwr_en=%b want 2/011", state, pwr_en);
    end
    #2;
    nreset = 1'b0;
    #1;
    n_tests++;
    if (state !== 3'd0 || pwr_en !== 3'b000 || ready !== 1'b0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_now got state=%0d pwr_en=%b ready=%b fault=%b want 0/000/0/0", state,
               pwr_en, ready, fault);
    end
    pgood = 3'b111;
    @(negedge clk);
    nreset = 1'b1;
    tick(1);  // fresh edge 0
    n_tests++;
    if (state !== 3'd1 || pwr_en !== 3'b001) begin
      n_fail++; $display("FAIL arst_restart got state=%0d pwr_en=%b want 1/001", state, pwr_en);
    end
    tick(12);  // fresh edge 12
    n_tests++;
    if (ready !== 1'b1 || state !== 3'd3) begin
      n_fail++; $display("FAIL arst_on got ready=%b state=%0d want 1/3", ready, state);
    end
  endtask

  initial begin
    nreset    = 1'b0;
    en        = 1'b0;
    cfg_delay = 8'd2;
    pgood     = 3'b111;
    test_reset();
    test_up();
    test_down();
    test_timeout();
    test_timeout_race();
    test_on_drop();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
